// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in, parallel-out frame loader:
// FSM state encodings and parity-mode selectors.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    LOAD  = 2'd3
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/shift_in_reg.sv
// n-bit serial shift register. MSB_FIRST selects whether the first
// bit shifted in ends up in q[n-1] or q[0].
module shift_in_reg #(
  parameter int n         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift,
  input  logic         sin,
  output logic [n-1:0] q
);

  logic [n-1:0] q_shifted;

  always_comb begin
    if (MSB_FIRST != 0) q_shifted = {q[n-2:0], sin};
    else                q_shifted = {sin, q[n-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (shift) q <= q_shifted;
  end

endmodule

// File: rtl/sipo_loader.sv
// Frame assembler: collects n serial bits (plus optional parity) after a
// start strobe and presents the word on d with a one-cycle en pulse.
//
// state | meaning
// IDLE  | waiting for start; sin_valid ignored
// SHIFT | accepting n data bits on sin_valid
// PAR   | waiting for the parity bit
// LOAD  | one cycle: en (good frame) or par_err (bad parity)
module sipo_loader
  import sipo_pkg::*;
#(
  parameter int n         = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY    = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sin_valid,
  input  logic         sin,
  output logic [n-1:0] d,
  output logic         en,
  output logic         busy,
  output logic         par_err
);

  localparam int   CW         = $clog2(n + 1);
  localparam logic PAR_TARGET = (PARITY == PAR_ODD) ? 1'b1 : 1'b0;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [n-1:0]  q;
  logic [n-1:0]  q_nxt;
  logic          par_acc;
  logic          clr, shift, last_bit, par_take, par_ok;

  assign clr      = (state == IDLE) && start;
  assign shift    = (state == SHIFT) && sin_valid;
  assign last_bit = (cnt == CW'(n - 1));
  assign par_take = (state == PAR) && sin_valid;
  assign par_ok   = ((par_acc ^ sin) == PAR_TARGET);
  assign busy     = (state != IDLE);

  shift_in_reg #(
    .n        (n),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .shift(shift),
    .sin  (sin),
    .q    (q)
  );

  // Word as it will look after this cycle's shift; lets d load on the
  // same edge as the final data bit when there is no parity phase.
  always_comb begin
    if (MSB_FIRST != 0) q_nxt = {q[n-2:0], sin};
    else                q_nxt = {sin, q[n-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (sin_valid && last_bit)
                 state_nxt = (PARITY != PAR_NONE) ? PAR : LOAD;
      PAR:     if (sin_valid) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      par_acc <= 1'b0;
      d       <= '0;
      en      <= 1'b0;
      par_err <= 1'b0;
    end else begin
      en      <= 1'b0;
      par_err <= 1'b0;
      if (clr) begin
        cnt     <= '0;
        par_acc <= 1'b0;
      end
      if (shift) begin
        cnt     <= cnt + CW'(1);
        par_acc <= par_acc ^ sin;
        if ((PARITY == PAR_NONE) && last_bit) begin
          d  <= q_nxt;
          en <= 1'b1;
        end
      end
      if (par_take) begin
        if (par_ok) begin
          d  <= q;
          en <= 1'b1;
        end else begin
          par_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sipo_loader.sv
// Directed bench: three loader configurations share stimulus; each
// scenario checks the instance whose configuration it targets.
module tb_sipo_loader;

  logic clk = 1'b0;
  logic rst, start, sin_valid, sin;

  logic [7:0] d_msb, d_lsb, d_par;
  logic       en_msb, en_lsb, en_par;
  logic       busy_msb, busy_lsb, busy_par;
  logic       pe_msb, pe_lsb, pe_par;

  int n_checks = 0;
  int n_errors = 0;
  int en_cnt   = 0;
  int en_base;

  always #5 clk = ~clk;

  always @(posedge clk) if (en_msb) en_cnt <= en_cnt + 1;

  sipo_loader #(.n(8), .MSB_FIRST(1), .PARITY(0)) u_msb (
    .clk(clk), .rst(rst), .start(start), .sin_valid(sin_valid), .sin(sin),
    .d(d_msb), .en(en_msb), .busy(busy_msb), .par_err(pe_msb)
  );

  sipo_loader #(.n(8), .MSB_FIRST(0), .PARITY(0)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .sin_valid(sin_valid), .sin(sin),
    .d(d_lsb), .en(en_lsb), .busy(busy_lsb), .par_err(pe_lsb)
  );

  sipo_loader #(.n(8), .MSB_FIRST(1), .PARITY(1)) u_par (
    .clk(clk), .rst(rst), .start(start), .sin_valid(sin_valid), .sin(sin),
    .d(d_par), .en(en_par), .busy(busy_par), .par_err(pe_par)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; sin_valid = 1'b0; sin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic bit_in(input logic b);
    sin_valid = 1'b1;
    sin       = b;
    tick();
    sin_valid = 1'b0;
  endtask

  // Sends bits[hi] first down to bits[lo].
  task automatic send_bits(input logic [8:0] bits, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) bit_in(bits[i]);
  endtask

  initial begin
    // 1: reset state and basic MSB-first load
    do_reset();
    chk("rst_d", d_msb, 8'h00);
    chk("rst_en", en_msb, 1'b0);
    chk("rst_busy", busy_msb, 1'b0);
    chk("rst_par_err", pe_par, 1'b0);
    start_frame();
    chk("s1_busy_after_start", busy_msb, 1'b1);
    send_bits(9'h0A5, 7, 0);
    chk("s1_en", en_msb, 1'b1);
    chk("s1_d", d_msb, 8'hA5);
    tick();
    chk("s1_en_drop", en_msb, 1'b0);
    chk("s1_busy_drop", busy_msb, 1'b0);
    chk("s1_d_held", d_msb, 8'hA5);

    // 2: LSB-first ordering
    do_reset();
    start_frame();
    send_bits(9'h0A5, 7, 0);
    chk("s2_en", en_lsb, 1'b1);
    chk("s2_d_pal", d_lsb, 8'hA5);
    tick();
    start_frame();
    send_bits(9'h080, 7, 0);
    chk("s2_d_lsb", d_lsb, 8'h01);
    chk("s2_d_msb", d_msb, 8'h80);

    // 3: even parity, good then bad frame
    do_reset();
    start_frame();
    send_bits({8'hA5, 1'b0}, 8, 1);
    chk("s3_par_wait_en", en_par, 1'b0);
    chk("s3_par_wait_d", d_par, 8'h00);
    bit_in(1'b0);
    chk("s3_good_en", en_par, 1'b1);
    chk("s3_good_d", d_par, 8'hA5);
    chk("s3_good_pe", pe_par, 1'b0);
    tick();
    start_frame();
    send_bits({8'h3C, 1'b1}, 8, 0);
    chk("s3_bad_pe", pe_par, 1'b1);
    chk("s3_bad_en", en_par, 1'b0);
    chk("s3_bad_d", d_par, 8'hA5);
    tick();
    chk("s3_pe_drop", pe_par, 1'b0);
    chk("s3_busy_drop", busy_par, 1'b0);

    // 4: gaps and ignored start mid-frame
    do_reset();
    en_base = en_cnt;
    start_frame();
    send_bits(9'h0A5, 7, 4);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("s4_busy_gap", busy_msb, 1'b1);
    send_bits(9'h0A5, 3, 0);
    chk("s4_en", en_msb, 1'b1);
    chk("s4_d", d_msb, 8'hA5);
    tick();
    tick();
    chk("s4_one_pulse", en_cnt - en_base, 1);

    // 5: reset mid-frame discards the partial word
    start_frame();
    send_bits(9'h0FF, 7, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_busy", busy_msb, 1'b0);
    chk("s5_d", d_msb, 8'h00);
    chk("s5_en", en_msb, 1'b0);
    chk("s5_pe", pe_par, 1'b0);
    start_frame();
    send_bits(9'h05A, 7, 0);
    chk("s5_reload_en", en_msb, 1'b1);
    chk("s5_reload_d", d_msb, 8'h5A);
    tick();

    // 6: back-to-back frames; start in LOAD is ignored
    do_reset();
    en_base = en_cnt;
    start_frame();
    send_bits(9'h012, 7, 0);
    chk("s6_first_d", d_msb, 8'h12);
    start = 1'b1;
    tick();
    chk("s6_load_start_ignored", busy_msb, 1'b0);
    tick();
    start = 1'b0;
    chk("s6_start_taken", busy_msb, 1'b1);
    send_bits(9'h034, 7, 0);
    chk("s6_second_en", en_msb, 1'b1);
    chk("s6_second_d", d_msb, 8'h34);
    tick();
    chk("s6_two_pulses", en_cnt - en_base, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
